// File: rtl/ecall_handler.sv
// RISC-V ecall service unit: conditions board inputs, runs print/read/exit services
// and holds the pipeline in stall until the service completes.
module ecall_handler #(
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ecall_valid,
    input  logic [31:0]     a7,
    input  logic [31:0]     a0,
    input  logic [SW_W-1:0] sw,
    input  logic            btn_confirm,
    output logic            stall,
    output logic [31:0]     ecall_wdata,
    output logic            ecall_wen,
    output logic [31:0]     seg_value,
    output logic            seg_valid,
    output logic            waiting,
    output logic            halted
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd2;
    localparam logic [2:0] S_DONE         = 3'd3;
    localparam logic [2:0] S_HALT         = 3'd4;

    localparam logic [7:0] SVC_PRINT   = 8'd1;
    localparam logic [7:0] SVC_CONFIRM = 8'd4;
    localparam logic [7:0] SVC_READ    = 8'd5;
    localparam logic [7:0] SVC_EXIT    = 8'd10;

    function automatic logic [31:0] sext_sw(input logic [SW_W-1:0] v);
        return 32'($signed(v));
    endfunction

    logic            btn_sync1_r, btn_sync2_r;
    logic [SW_W-1:0] sw_sync1_r, sw_sync2_r;
    logic            db_level_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic [2:0]      state_r, state_next_s;
    logic [7:0]      svc_r;
    logic [31:0]     ecall_wdata_r, seg_value_r;
    logic            ecall_wen_r, seg_valid_r;
    logic            db_diff_s, db_flip_s, press_s, release_s;
    logic            accept_s, unused_a7_s;

    assign unused_a7_s = ^a7[31:8];
    assign accept_s    = (state_r == S_IDLE) && ecall_valid;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync1_r <= 1'b0;
            btn_sync2_r <= 1'b0;
            sw_sync1_r  <= '0;
            sw_sync2_r  <= '0;
        end else begin
            btn_sync1_r <= btn_confirm;
            btn_sync2_r <= btn_sync1_r;
            sw_sync1_r  <= sw;
            sw_sync2_r  <= sw_sync1_r;
        end
    end

    assign db_diff_s = btn_sync2_r ^ db_level_r;
    assign db_flip_s = db_diff_s && (db_cnt_r == CNT_MAX);
    assign press_s   = db_flip_s && !db_level_r;
    assign release_s = db_flip_s && db_level_r;

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
        end else if (!db_diff_s) begin
            db_cnt_r   <= '0;
        end else if (db_cnt_r == CNT_MAX) begin
            db_level_r <= ~db_level_r;
            db_cnt_r   <= '0;
        end else begin
            db_cnt_r   <= db_cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic; a dropped ecall_valid during a wait is a pipeline flush
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (ecall_valid) begin
                    case (a7[7:0])
                        SVC_CONFIRM, SVC_READ: state_next_s = S_WAIT_PRESS;
                        SVC_EXIT:              state_next_s = S_HALT;
                        default:               state_next_s = S_DONE;
                    endcase
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT_PRESS: begin
                if (!ecall_valid)  state_next_s = S_IDLE;
                else if (press_s)  state_next_s = S_WAIT_RELEASE;
                else               state_next_s = S_WAIT_PRESS;
            end
            S_WAIT_RELEASE: begin
                if (!ecall_valid)   state_next_s = S_IDLE;
                else if (release_s) state_next_s = S_DONE;
                else                state_next_s = S_WAIT_RELEASE;
            end
            S_DONE:  state_next_s = S_IDLE;
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State and latched service code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            svc_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) svc_r <= a7[7:0];
        end
    end

    // Registered service outputs: display, read value and writeback strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_value_r   <= 32'd0;
            seg_valid_r   <= 1'b0;
            ecall_wdata_r <= 32'd0;
            ecall_wen_r   <= 1'b0;
        end else begin
            ecall_wen_r <= (state_r == S_WAIT_RELEASE) && ecall_valid && release_s
                           && (svc_r == SVC_READ);
            if (accept_s && ((a7[7:0] == SVC_PRINT) || (a7[7:0] == SVC_CONFIRM))) begin
                seg_value_r <= a0;
                seg_valid_r <= 1'b1;
            end
            if ((state_r == S_WAIT_PRESS) && ecall_valid && press_s && (svc_r == SVC_READ)) begin
                ecall_wdata_r <= sext_sw(sw_sync2_r);
            end
        end
    end

    // Pipeline stall, forced low while reset is held
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = 1'b0;
        end else begin
            case (state_r)
                S_IDLE:                               stall = ecall_valid;
                S_WAIT_PRESS, S_WAIT_RELEASE, S_HALT: stall = 1'b1;
                default:                              stall = 1'b0;
            endcase
        end
    end

    assign waiting     = (state_r == S_WAIT_PRESS) || (state_r == S_WAIT_RELEASE);
    assign halted      = (state_r == S_HALT);
    assign ecall_wdata = ecall_wdata_r;
    assign ecall_wen   = ecall_wen_r;
    assign seg_value   = seg_value_r;
    assign seg_valid   = seg_valid_r;

endmodule

// File: tb/tb_ecall_handler.sv
// Scoreboard bench for ecall_handler: expected retire results are queued at issue
// and checked by a monitor whenever an ecall retires (ecall_valid high, stall low).
module tb_ecall_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ecall_valid = 1'b0;
    logic [31:0] a7 = 32'd0, a0 = 32'd0;
    logic [15:0] sw = 16'd0;
    logic        btn_confirm = 1'b0;
    logic        stall, ecall_wen, seg_valid, waiting, halted;
    logic [31:0] ecall_wdata, seg_value;

    ecall_handler #(.SW_W(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ecall_valid(ecall_valid), .a7(a7), .a0(a0),
        .sw(sw), .btn_confirm(btn_confirm), .stall(stall), .ecall_wdata(ecall_wdata),
        .ecall_wen(ecall_wen), .seg_value(seg_value), .seg_valid(seg_valid),
        .waiting(waiting), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] seg;
        logic        segv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pop and compare on every retire; any writeback strobe elsewhere is an error
    always @(negedge clk) begin
        if (reset && ecall_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("retire_wen", {31'd0, ecall_wen}, {31'd0, mon_e.wen});
                if (mon_e.wen) check("retire_wdata", ecall_wdata, mon_e.wdata);
                check("retire_seg_value", seg_value, mon_e.seg);
                check("retire_seg_valid", {31'd0, seg_valid}, {31'd0, mon_e.segv});
            end
        end else if (ecall_wen) begin
            check("stray_wen", 32'd1, 32'd0);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        a7 = code;
        a0 = arg;
        ecall_valid = 1'b1;
    endtask

    // Waits for the retire cycle; n counts cycles from issue including the retire cycle
    task automatic wait_retire(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (!stall) break;
            if (n >= 200) begin
                check("retire_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int n;
    int bad;

    initial begin
        // Reset state, with ecall_valid high to show stall is forced low
        ecall_valid = 1'b1;
        a7 = 32'd1;
        cyc(2);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wen", {31'd0, ecall_wen}, 32'd0);
        check("rst_wdata", ecall_wdata, 32'd0);
        check("rst_seg", {seg_value[30:0], seg_valid}, 32'd0);
        check("rst_wait_halt", {30'd0, waiting, halted}, 32'd0);
        ecall_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(2);

        // Print: 2-cycle completion
        exp_q.push_back('{1'b0, 32'd0, 32'h0000_1234, 1'b1});
        issue(32'd1, 32'h0000_1234);
        wait_retire(n);
        ecall_valid = 1'b0;
        check("print_cycles", n, 32'd2);
        cyc(2);

        // Read negative with a short release glitch that must be ignored
        sw = 16'hFFFE;
        exp_q.push_back('{1'b1, 32'hFFFF_FFFE, 32'h0000_1234, 1'b1});
        issue(32'd5, 32'h0);
        cyc(1);
        @(negedge clk);
        check("read_waiting_press", {31'd0, waiting}, 32'd1);
        @(posedge clk); #1;
        btn_confirm = 1'b1;
        cyc(10);
        btn_confirm = 1'b0;
        cyc(2);
        btn_confirm = 1'b1;
        cyc(8);
        @(negedge clk);
        check("read_waiting_release", {30'd0, waiting, stall}, 32'd3);
        @(posedge clk); #1;
        btn_confirm = 1'b0;
        wait_retire(n);
        ecall_valid = 1'b0;
        cyc(10);

        // Debounce: bounce produces no press; sw latched at the press, not after
        sw = 16'h0001;
        exp_q.push_back('{1'b1, 32'h0000_0003, 32'h0000_1234, 1'b1});
        issue(32'd5, 32'h0);
        cyc(1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn_confirm = ~btn_confirm;
            @(negedge clk);
            if (!stall || !waiting) bad++;
            @(posedge clk); #1;
        end
        check("bounce_no_complete", bad, 32'd0);
        sw = 16'h0003;
        btn_confirm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) sw = 16'h0007;
            cyc(1);
        end
        btn_confirm = 1'b0;
        wait_retire(n);
        ecall_valid = 1'b0;
        cyc(10);

        // Abort of svc 4 in WAIT_PRESS: display already loaded at acceptance
        issue(32'd4, 32'hCAFE_0004);
        cyc(2);
        @(negedge clk);
        check("abort_waiting", {31'd0, waiting}, 32'd1);
        @(posedge clk); #1;
        ecall_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle", {30'd0, stall, waiting}, 32'd0);
        check("abort_seg", seg_value, 32'hCAFE_0004);
        @(posedge clk); #1;

        // Full print-and-confirm
        exp_q.push_back('{1'b0, 32'd0, 32'h0000_0044, 1'b1});
        issue(32'd4, 32'h0000_0044);
        cyc(2);
        btn_confirm = 1'b1;
        cyc(8);
        btn_confirm = 1'b0;
        wait_retire(n);
        ecall_valid = 1'b0;
        cyc(10);

        // Back-to-back print then unknown code
        exp_q.push_back('{1'b0, 32'd0, 32'h0000_0055, 1'b1});
        issue(32'd1, 32'h0000_0055);
        wait_retire(n);
        check("b2b_first_cycles", n, 32'd2);
        exp_q.push_back('{1'b0, 32'd0, 32'h0000_0055, 1'b1});
        issue(32'd7, 32'h0000_0099);
        wait_retire(n);
        ecall_valid = 1'b0;
        check("b2b_unknown_cycles", n, 32'd2);
        cyc(2);

        // Exit holds regardless of inputs
        issue(32'd10, 32'h0);
        cyc(1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            ecall_valid = 1'($urandom_range(0, 1));
            a7 = $urandom;
            a0 = $urandom;
            btn_confirm = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!halted || !stall) bad++;
            @(posedge clk); #1;
        end
        check("halt_hold", bad, 32'd0);
        ecall_valid = 1'b1;
        btn_confirm = 1'b0;
        reset = 1'b0;
        #1;
        check("halt_reset_stall_halted", {30'd0, stall, halted}, 32'd0);
        check("halt_reset_seg", {seg_value[30:0], seg_valid}, 32'd0);
        cyc(2);
        ecall_valid = 1'b0;
        reset = 1'b1;
        cyc(3);

        exp_q.push_back('{1'b0, 32'd0, 32'h0000_0077, 1'b1});
        issue(32'd1, 32'h0000_0077);
        wait_retire(n);
        ecall_valid = 1'b0;
        check("post_reset_print_cycles", n, 32'd2);
        cyc(3);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
